// File: rtl/store_align_buffer_if.sv
// Bus bundle for store_align_buffer: pipeline store/load slot, stall and
// hazard feedback, and the data memory write port with its req/ack handshake.
interface store_align_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Pipeline side
    logic             halt;
    logic             bubble_in;
    logic             is_store;
    logic             is_load;
    logic [4:0]       opcode;
    logic [31:0]      addr;
    logic [31:0]      store_data;
    logic             stall;
    logic             load_hazard;

    // Data memory write port
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;

    // Status
    logic             empty;
    logic [CNT_W-1:0] count;

    // Driver of the pipeline slot and the memory acknowledge
    modport master (
        output halt, bubble_in, is_store, is_load, opcode, addr, store_data, mem_ack,
        input  stall, load_hazard, mem_req, mem_addr, mem_wdata, mem_be, empty, count
    );

    // The store buffer itself
    modport slave (
        input  halt, bubble_in, is_store, is_load, opcode, addr, store_data, mem_ack,
        output stall, load_hazard, mem_req, mem_addr, mem_wdata, mem_be, empty, count
    );
endinterface

// File: rtl/store_align_buffer.sv
// Store alignment buffer: turns byte/halfword/word stores into word-aligned
// writes with byte enables, queues them in a DEPTH-entry FIFO and drains the
// head entry to data memory over req/ack. Raises stall when a store meets a
// full queue and load_hazard when a load hits the word of a pending store.
module store_align_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    store_align_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue state
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic [DEPTH-1:0] valid_reg;

    // Entry payload; only ever read behind a valid bit, so it needs no reset
    logic [29:0]      entry_word_reg [DEPTH];
    logic [31:0]      entry_data_reg [DEPTH];
    logic [3:0]       entry_be_reg   [DEPTH];

    // Aligned form of the incoming store
    logic             op_in_range;
    logic [3:0]       align_be;
    logic [31:0]      align_data;

    logic             full;
    logic             store_slot;
    logic             enq;
    logic             pop;
    logic [DEPTH-1:0] hit;

    // Lane alignment: pick byte enables and shift data into its lanes from
    // the opcode size class and the low address bits
    always_comb begin
        op_in_range = (bus.opcode >= 5'd3) && (bus.opcode <= 5'd11);
        align_be    = 4'b0000;
        align_data  = 32'h0000_0000;
        if (bus.opcode <= 5'd5) begin
            align_be   = 4'b1111;
            align_data = bus.store_data;
        end else if (bus.opcode <= 5'd8) begin
            case (bus.addr[1:0])
                2'b00: begin
                    align_be   = 4'b0011;
                    align_data = {16'h0000, bus.store_data[15:0]};
                end
                2'b01: begin
                    align_be   = 4'b0110;
                    align_data = {8'h00, bus.store_data[15:0], 8'h00};
                end
                default: begin
                    align_be   = 4'b1100;
                    align_data = {bus.store_data[15:0], 16'h0000};
                end
            endcase
        end else begin
            align_be   = 4'b0001 << bus.addr[1:0];
            align_data = {24'h000000, bus.store_data[7:0]} << {bus.addr[1:0], 3'b000};
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never
    // makes room for a store in that cycle
    assign full       = (count_reg == CNT_W'(DEPTH));
    assign store_slot = bus.is_store && !bus.bubble_in && op_in_range;
    assign enq        = store_slot && !bus.halt && !full;
    assign pop        = bus.mem_req && bus.mem_ack;

    // Per-entry word match against the load address
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit[gi] = valid_reg[gi] && (entry_word_reg[gi] == bus.addr[31:2]);
        end
    endgenerate

    assign bus.stall       = store_slot && full;
    assign bus.load_hazard = bus.is_load && !bus.bubble_in && (|hit);

    // Head entry presented to memory; forced to zero when nothing is pending
    assign bus.mem_req   = (count_reg != '0);
    assign bus.mem_addr  = bus.mem_req ? {entry_word_reg[head_reg], 2'b00} : 32'h0000_0000;
    assign bus.mem_wdata = bus.mem_req ? entry_data_reg[head_reg] : 32'h0000_0000;
    assign bus.mem_be    = bus.mem_req ? entry_be_reg[head_reg] : 4'b0000;
    assign bus.empty     = (count_reg == '0);
    assign bus.count     = count_reg;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (enq) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            if (enq && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !enq) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Valid bits: set at the tail on enqueue, cleared at the head on pop.
    // Both cannot target the same slot: that would need a full queue,
    // where enqueue is blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enq && (tail_reg == PTR_W'(i))) begin
                    valid_reg[i] <= 1'b1;
                end else if (pop && (head_reg == PTR_W'(i))) begin
                    valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Payload write at the tail slot on enqueue
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_word_reg[tail_reg] <= bus.addr[31:2];
            entry_data_reg[tail_reg] <= align_data;
            entry_be_reg[tail_reg]   <= align_be;
        end
    end
endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer: alignment, FIFO order and wrap,
// full/stall, dropped opcodes, load hazard and asynchronous reset.
module tb_store_align_buffer;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    store_align_buffer_if #(.DEPTH(4)) bus ();

    store_align_buffer #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a store for exactly one rising edge
    task automatic push(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d);
        $display("[TB] store op=%0d addr=0x%08h data=0x%08h", op, a, d);
        bus.is_store   = 1'b1;
        bus.opcode     = op;
        bus.addr       = a;
        bus.store_data = d;
        @(negedge clk);
        bus.is_store   = 1'b0;
    endtask

    task automatic head(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
        check({tag, "_req"}, {31'b0, bus.mem_req}, 32'd1);
        check({tag, "_addr"}, bus.mem_addr, a);
        check({tag, "_wdata"}, bus.mem_wdata, d);
        check({tag, "_be"}, {28'b0, bus.mem_be}, {28'b0, be});
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        bus.halt       = 1'b0;
        bus.bubble_in  = 1'b0;
        bus.is_store   = 1'b0;
        bus.is_load    = 1'b0;
        bus.opcode     = 5'd0;
        bus.addr       = 32'h0;
        bus.store_data = 32'h0;
        bus.mem_ack    = 1'b0;

        // Reset state
        #12;
        check("rst_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst_be", {28'b0, bus.mem_be}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_empty", {31'b0, bus.empty}, 32'd1);
        check("rst_count", {29'b0, bus.count}, 32'd0);
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        check("rst_haz", {31'b0, bus.load_hazard}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Byte store with ack already high: one cycle of occupancy
        bus.mem_ack = 1'b1;
        push(5'd9, 32'h0000_1003, 32'h0000_00AB);
        head("byte", 32'h0000_1000, 32'hAB00_0000, 4'b1000);
        check("byte_cnt1", {29'b0, bus.count}, 32'd1);
        @(negedge clk);
        check("byte_cnt0", {29'b0, bus.count}, 32'd0);
        check("byte_empty", {31'b0, bus.empty}, 32'd1);
        check("byte_req0", {31'b0, bus.mem_req}, 32'd0);
        bus.mem_ack = 1'b0;

        // Out-of-range opcode is dropped: no stall, no enqueue
        bus.is_store = 1'b1;
        bus.opcode   = 5'd12;
        #1;
        check("drop_stall", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.is_store = 1'b0;
        check("drop_empty", {31'b0, bus.empty}, 32'd1);

        // Halfword stores at three offsets, drained in order
        push(5'd6, 32'h0000_0020, 32'h0000_1234);
        push(5'd6, 32'h0000_0021, 32'h0000_1234);
        push(5'd6, 32'h0000_0022, 32'h0000_1234);
        check("half_cnt", {29'b0, bus.count}, 32'd3);
        head("half0", 32'h0000_0020, 32'h0000_1234, 4'b0011);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        head("half1", 32'h0000_0020, 32'h0012_3400, 4'b0110);
        @(negedge clk);
        head("half2", 32'h0000_0020, 32'h1234_0000, 4'b1100);
        @(negedge clk);
        check("half_empty", {31'b0, bus.empty}, 32'd1);
        bus.mem_ack = 1'b0;

        // Fill with ack low, then a 5th store stalls
        for (int k = 0; k < 4; k++) begin
            push(5'd3, 32'h0000_0100 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1));
        end
        check("fill_cnt", {29'b0, bus.count}, 32'd4);
        check("fill_hold", bus.mem_wdata, 32'h1111_1111);
        bus.is_store   = 1'b1;
        bus.opcode     = 5'd3;
        bus.addr       = 32'h0000_0200;
        bus.store_data = 32'hDEAD_BEEF;
        #1;
        check("full_stall", {31'b0, bus.stall}, 32'd1);
        bus.opcode = 5'd13;
        #1;
        check("full_drop_stall", {31'b0, bus.stall}, 32'd0);
        bus.opcode = 5'd3;
        @(negedge clk);
        check("full_cnt", {29'b0, bus.count}, 32'd4);
        // Full blocks enqueue even with a pop in the same cycle
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.is_store = 1'b0;
        check("full_pop_cnt", {29'b0, bus.count}, 32'd3);
        for (int k = 1; k < 4; k++) begin
            head("drain", 32'h0000_0100 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), 4'b1111);
            @(negedge clk);
        end
        check("drain_empty", {31'b0, bus.empty}, 32'd1);
        bus.mem_ack = 1'b0;

        // Move pointers to slot 3, then enqueue+pop at count 2 across the wrap
        for (int k = 0; k < 3; k++) begin
            push(5'd10, 32'h0000_0300, 32'h0000_00C0 + 32'(k));
        end
        bus.mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        bus.mem_ack = 1'b0;
        check("wrap_empty", {31'b0, bus.empty}, 32'd1);
        push(5'd3, 32'h0000_0400, 32'hAAAA_0001);
        push(5'd3, 32'h0000_0404, 32'hAAAA_0002);
        check("sim_cnt_pre", {29'b0, bus.count}, 32'd2);
        head("sim_a", 32'h0000_0400, 32'hAAAA_0001, 4'b1111);
        bus.mem_ack = 1'b1;
        push(5'd3, 32'h0000_0408, 32'hAAAA_0003);
        check("sim_cnt", {29'b0, bus.count}, 32'd2);
        head("sim_b", 32'h0000_0404, 32'hAAAA_0002, 4'b1111);
        @(negedge clk);
        head("sim_c", 32'h0000_0408, 32'hAAAA_0003, 4'b1111);
        @(negedge clk);
        check("sim_empty", {31'b0, bus.empty}, 32'd1);
        bus.mem_ack = 1'b0;

        // Load hazard against a pending word store at 0x104
        push(5'd4, 32'h0000_0104, 32'h0BAD_F00D);
        bus.is_load = 1'b1;
        bus.addr    = 32'h0000_0107;
        #1;
        check("haz_hit", {31'b0, bus.load_hazard}, 32'd1);
        bus.addr = 32'h0000_0108;
        #1;
        check("haz_miss", {31'b0, bus.load_hazard}, 32'd0);
        bus.addr      = 32'h0000_0107;
        bus.bubble_in = 1'b1;
        #1;
        check("haz_bubble", {31'b0, bus.load_hazard}, 32'd0);
        bus.bubble_in = 1'b0;
        bus.is_load   = 1'b0;
        @(negedge clk);

        // Asynchronous reset with three entries pending
        push(5'd5, 32'h0000_0500, 32'h0000_0001);
        push(5'd5, 32'h0000_0504, 32'h0000_0002);
        check("pre_rst_cnt", {29'b0, bus.count}, 32'd3);
        check("pre_rst_req", {31'b0, bus.mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", {31'b0, bus.mem_req}, 32'd0);
        check("arst_cnt", {29'b0, bus.count}, 32'd0);
        check("arst_be", {28'b0, bus.mem_be}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Halt blocks enqueue
        bus.halt = 1'b1;
        push(5'd3, 32'h0000_0600, 32'h0000_0066);
        bus.halt = 1'b0;
        check("halt_cnt", {29'b0, bus.count}, 32'd0);
        check("halt_empty", {31'b0, bus.empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/store_align_buffer.md
# store_align_buffer

Store-side counterpart of the writeback load extractor: converts a byte/halfword/word store into a word-aligned memory write with per-lane byte enables. Buffers up to DEPTH stores in a FIFO and drains them to the data memory write port over a req/ack handshake. Sits alongside the memory stage, receiving store traffic from execute and feeding the data memory. It stalls the pipe when full and flags loads that hit a pending store's word.

## Interface
- DEPTH, 4, store FIFO entries; power of two, ≥2
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- halt  in  1  pipeline halt; blocks enqueue only, drain continues
- bubble_in  in  1  slot is a bubble; no enqueue, no hazard check
- is_store  in  1  slot holds a store
- is_load  in  1  slot holds a load (hazard check only)
- opcode  in  5  3–5 word, 6–8 halfword, 9–11 byte; other values not enqueued
- addr  in  32  byte address of store or load
- store_data  in  32  value in low bits (byte in [7:0], halfword in [15:0])
- stall  out  1  store presented while full; upstream holds slot
- load_hazard  out  1  load targets the word of a pending entry
- mem_req  out  1  head entry valid
- mem_addr  out  32  {head addr[31:2], 2'b00}
- mem_wdata  out  32  lane-aligned head data
- mem_be  out  4  head byte enables, bit i = byte lane i ([8i+7:8i])
- mem_ack  in  1  memory accepted head this cycle
- empty  out  1  no entries
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Lane alignment at enqueue, from opcode class and addr[1:0]:
  - word: be=1111, wdata=store_data; addr[1:0] ignored.
  - halfword 00: be=0011, data<<0; 01: be=0110, data[15:0]<<8; 1x: be=1100, data[15:0]<<16.
  - byte: be=1<<addr[1:0], wdata=data[7:0]<<(8*addr[1:0]).
  - Non-enabled lanes of wdata are zero.
- Enqueue when is_store && !bubble_in && !halt && 3≤opcode≤11 && count<DEPTH. The entry is written to tail and tail increments.
- stall = is_store && !bubble_in && 3≤opcode≤11 && count==DEPTH. Combinational.
- A store with an out-of-range opcode is dropped silently: no enqueue, no stall.
- Drain: mem_req=!empty. mem_addr/mem_wdata/mem_be come from the head entry. An entry pops when mem_req && mem_ack at a rising edge.
- While mem_req is high and ack is low, head outputs are held stable.
- load_hazard = is_load && !bubble_in && some valid entry has entry addr[31:2]==addr[31:2]. Combinational. No lane-overlap refinement, no forwarding.
- Simultaneous enqueue and pop: both occur and count is unchanged.
- Full: enqueue is blocked even if a pop happens the same cycle. Full is decided on the registered count.
- Empty: pop is impossible because mem_req=0. mem_ack while empty is ignored.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous, any time): head=tail=0, count=0, all entry valid bits 0.
  - mem_req=0, mem_be=0, mem_addr=0, mem_wdata=0, empty=1.
  - stall and load_hazard are 0 unless inputs assert them.
- Reset mid-drain abandons pending stores with no completion.
- Latency: a store enqueued at edge N has mem_req=1 during cycle N→N+1 if the FIFO was empty.
- Minimum occupancy is 1 cycle with immediate ack.
- Throughput: one pop per cycle when mem_ack is held high.
- count and empty are updated at the same edge as enqueue/pop.
- load_hazard and stall depend on the current registered state only. A same-cycle enqueue or pop takes effect next cycle.

## Test plan
- Byte store opcode=9, addr=0x1003, data=0xAB, ack high: next cycle mem_req=1, mem_addr=0x1000, mem_be=1000, mem_wdata=0xAB000000. Count 1→0 after ack edge.
- Halfword stores opcode=6, data=0x1234 at addr 0x20, 0x21, 0x22: be 0011/0110/1100, wdata 0x00001234/0x00123400/0x12340000. All at mem_addr 0x20, drained in order.
- Fill with ack=0: 4 word stores enqueue and count=4. 5th store gives stall=1 and is not enqueued. Raise ack: 4 pops on consecutive cycles, then empty=1.
- Simultaneous enqueue and pop at count=2: count stays 2 and FIFO order is preserved. Wrap across index DEPTH-1→0 is verified by data order.
- Hazard: pending store at 0x104. Load at addr 0x107 gives load_hazard=1. Load at 0x108 gives 0. Load with bubble_in=1 gives 0.
- Assert rst with 3 entries and mem_req high: mem_req drops asynchronously, count=0. After release, halt=1 with a store presented gives no enqueue.
